// File: rtl/lsu.sv
// Load/store unit: memory stage that runs loads and stores over a req/ack bus and registers the writeback bundle.
// Build option LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
package lsu_pkg;
    localparam int MS_XLEN = 32;

    typedef struct packed {
        logic [2:0]         funct3;
        logic               mm_re;
        logic               mm_we;
        logic [MS_XLEN-1:0] mm_addr;
        logic [MS_XLEN-1:0] data;
        logic [4:0]         rd_addr;
    } memory_signals_t;
endpackage

module lsu #(
    parameter int XLEN = 32,
    parameter int BE_W = XLEN / 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     valid_in,
    input  lsu_pkg::memory_signals_t signals_in,
    input  logic [XLEN-1:0]          store_data,
    output logic                     stall,
    output logic                     bus_req,
    output logic                     bus_we,
    output logic [XLEN-1:0]          bus_addr,
    output logic [XLEN-1:0]          bus_wdata,
    output logic [BE_W-1:0]          bus_be,
    input  logic                     bus_ack,
    input  logic [XLEN-1:0]          bus_rdata,
    output logic                     wb_valid,
    output logic [4:0]               wb_rd_addr,
    output logic [XLEN-1:0]          wb_rd_data,
    output logic                     misalign
);

    typedef enum logic {IDLE, BUS} state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_addr_q, wb_rd_addr_d;
    logic [XLEN-1:0]   wb_rd_data_q, wb_rd_data_d;

    logic              mem_op;
    logic [1:0]        acc_off;
    logic              misal_det;

    function automatic logic [BE_W-1:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'd0:    return BE_W'(4'b0001) << off;
            2'd1:    return BE_W'(4'b0011) << off;
            default: return BE_W'(4'b1111);
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] f3, input logic [XLEN-1:0] sd);
        case (f3[1:0])
            2'd0:    return {4{sd[7:0]}};
            2'd1:    return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [1:0] off,
                                                     input logic [2:0] f3);
        logic [XLEN-1:0]        lane;
        logic signed [7:0]      b;
        logic signed [15:0]     h;
        logic signed [XLEN-1:0] s;
        lane = word >> {off, 3'b000};
        b    = lane[7:0];
        h    = lane[15:0];
        case (f3[1:0])
            2'd0:    s = f3[2] ? XLEN'($unsigned(b)) : XLEN'(b);
            2'd1:    s = f3[2] ? XLEN'($unsigned(h)) : XLEN'(h);
            default: s = lane;
        endcase
        return s;
    endfunction

    assign mem_op  = signals_in.mm_re | signals_in.mm_we;
    assign acc_off = signals_in.mm_addr[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    assign misal_det = ((signals_in.funct3[1:0] == 2'd1) && acc_off[0]) ||
                       ((signals_in.funct3[1:0] == 2'd2) && (acc_off != 2'd0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) misalign_q <= 1'b0;
        else          misalign_q <= (state_q == IDLE) && valid_in && mem_op && misal_det;
    end

    assign misalign = misalign_q;
`else
    assign misal_det = 1'b0;
    assign misalign  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        rd_d         = rd_q;
        wb_valid_d   = 1'b0;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_rd_data_d = wb_rd_data_q;
        stall        = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (!mem_op) begin
                        wb_valid_d   = 1'b1;
                        wb_rd_addr_d = signals_in.rd_addr;
                        wb_rd_data_d = signals_in.data;
                    end else if (!misal_det) begin
                        // a set mm_we wins, so re+we behaves as a store
                        stall       = 1'b1;
                        state_d     = BUS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = signals_in.mm_we;
                        bus_addr_d  = {signals_in.mm_addr[XLEN-1:2], 2'b00};
                        bus_be_d    = lane_be(signals_in.funct3, acc_off);
                        bus_wdata_d = lane_wdata(signals_in.funct3, store_data);
                        funct3_d    = signals_in.funct3;
                        off_d       = acc_off;
                        rd_d        = signals_in.rd_addr;
                    end
                end
            end
            BUS: begin
                stall = 1'b1;
                if (bus_ack) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        wb_valid_d   = 1'b1;
                        wb_rd_addr_d = rd_q;
                        wb_rd_data_d = load_extract(bus_rdata, off_q, funct3_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_rd_data_q <= '0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_rd_data_q <= wb_rd_data_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_be     = bus_be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd_addr = wb_rd_addr_q;
    assign wb_rd_data = wb_rd_data_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: ALU passthrough, loads/stores with a small bus memory, reset mid-transaction, misalign option.
module tb_lsu;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b1;
    logic                     valid_in = 1'b0;
    lsu_pkg::memory_signals_t signals_in = '0;
    logic [31:0]              store_data = '0;
    logic                     stall;
    logic                     bus_req;
    logic                     bus_we;
    logic [31:0]              bus_addr;
    logic [31:0]              bus_wdata;
    logic [3:0]               bus_be;
    logic                     bus_ack = 1'b0;
    logic [31:0]              bus_rdata = '0;
    logic                     wb_valid;
    logic [4:0]               wb_rd_addr;
    logic [31:0]              wb_rd_data;
    logic                     misalign;

    int checks = 0;
    int passed = 0;

    logic [31:0] mem [logic [31:0]];

    int          o_stall_cnt;
    logic        o_req, o_we, o_hold_ok, o_wbv, o_post_stall, o_post_req;
    logic [31:0] o_addr, o_wdata, o_wbd;
    logic [3:0]  o_be;
    logic [4:0]  o_wbr;

    lsu dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid_in   (valid_in),
        .signals_in (signals_in),
        .store_data (store_data),
        .stall      (stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .wb_valid   (wb_valid),
        .wb_rd_addr (wb_rd_addr),
        .wb_rd_data (wb_rd_data),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic lsu_pkg::memory_signals_t mk(input logic [2:0] f3, input logic re, input logic we,
                                                    input logic [31:0] addr, input logic [31:0] data,
                                                    input logic [4:0] rd);
        lsu_pkg::memory_signals_t s;
        s.funct3  = f3;
        s.mm_re   = re;
        s.mm_we   = we;
        s.mm_addr = addr;
        s.data    = data;
        s.rd_addr = rd;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the edge following the ack.
    task automatic run_mem(input lsu_pkg::memory_signals_t s, input logic [31:0] sd, input int waits);
        logic [31:0] tmp;
        valid_in   = 1'b1;
        signals_in = s;
        store_data = sd;
        #1;
        o_stall_cnt = int'(stall);
        tick();
        valid_in   = 1'b0;
        signals_in = '0;
        store_data = '0;
        o_req   = bus_req;
        o_we    = bus_we;
        o_addr  = bus_addr;
        o_wdata = bus_wdata;
        o_be    = bus_be;
        o_hold_ok = 1'b1;
        for (int i = 0; i < waits; i++) begin
            o_stall_cnt += int'(stall);
            if (bus_req !== o_req || bus_addr !== o_addr || bus_be !== o_be ||
                bus_wdata !== o_wdata || bus_we !== o_we) o_hold_ok = 1'b0;
            tick();
        end
        if (bus_req !== o_req || bus_addr !== o_addr || bus_be !== o_be ||
            bus_wdata !== o_wdata || bus_we !== o_we) o_hold_ok = 1'b0;
        o_stall_cnt += int'(stall);
        tmp = mem.exists(o_addr) ? mem[o_addr] : 32'h0;
        bus_ack = 1'b1;
        if (o_we) begin
            for (int k = 0; k < 4; k++)
                if (o_be[k]) tmp[k*8 +: 8] = o_wdata[k*8 +: 8];
            mem[o_addr] = tmp;
            bus_rdata = 32'h0;
        end else begin
            bus_rdata = tmp;
        end
        tick();
        bus_ack      = 1'b0;
        bus_rdata    = 32'h0;
        o_wbv        = wb_valid;
        o_wbd        = wb_rd_data;
        o_wbr        = wb_rd_addr;
        o_post_stall = stall;
        o_post_req   = bus_req;
    endtask

    initial begin
        mem[32'h1000] = 32'h80FF_FF00;
        mem[32'h2000] = 32'hBEEF_0000;
        mem[32'h5000] = 32'h4433_2211;

        #2 reset_n = 1'b0;
        tick();
        tick();
        chk("rst_bus_req",   {31'b0, bus_req},  32'h0);
        chk("rst_bus_we",    {31'b0, bus_we},   32'h0);
        chk("rst_bus_addr",  bus_addr,          32'h0);
        chk("rst_bus_wdata", bus_wdata,         32'h0);
        chk("rst_bus_be",    {28'b0, bus_be},   32'h0);
        chk("rst_wb_valid",  {31'b0, wb_valid}, 32'h0);
        chk("rst_wb_rd",     {27'b0, wb_rd_addr}, 32'h0);
        chk("rst_wb_data",   wb_rd_data,        32'h0);
        chk("rst_misalign",  {31'b0, misalign}, 32'h0);
        chk("rst_stall",     {31'b0, stall},    32'h0);
        reset_n = 1'b1;
        tick();

        // ALU passthrough
        valid_in   = 1'b1;
        signals_in = mk(3'b000, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 5'd5);
        #1;
        chk("alu_stall", {31'b0, stall}, 32'h0);
        tick();
        valid_in   = 1'b0;
        signals_in = '0;
        chk("alu_wb_valid", {31'b0, wb_valid},   32'h1);
        chk("alu_wb_rd",    {27'b0, wb_rd_addr}, 32'd5);
        chk("alu_wb_data",  wb_rd_data,          32'h1234_5678);
        chk("alu_no_req",   {31'b0, bus_req},    32'h0);
        tick();
        chk("alu_wb_pulse", {31'b0, wb_valid},   32'h0);
        chk("alu_no_req2",  {31'b0, bus_req},    32'h0);

        // LB sign-extend, 3 wait cycles
        run_mem(mk(3'b000, 1'b1, 1'b0, 32'h1003, 32'h0, 5'd7), 32'h0, 3);
        chk("lb_req",     {31'b0, o_req},     32'h1);
        chk("lb_addr",    o_addr,             32'h1000);
        chk("lb_be",      {28'b0, o_be},      32'h8);
        chk("lb_we",      {31'b0, o_we},      32'h0);
        chk("lb_hold",    {31'b0, o_hold_ok}, 32'h1);
        chk("lb_stalls",  o_stall_cnt,        32'd5);
        chk("lb_wbv",     {31'b0, o_wbv},     32'h1);
        chk("lb_wbr",     {27'b0, o_wbr},     32'd7);
        chk("lb_wbd",     o_wbd,              32'hFFFF_FF80);
        chk("lb_post_st", {31'b0, o_post_stall}, 32'h0);
        chk("lb_post_rq", {31'b0, o_post_req},   32'h0);
        tick();
        chk("lb_wb_pulse", {31'b0, wb_valid}, 32'h0);

        // LHU, immediate ack
        run_mem(mk(3'b101, 1'b1, 1'b0, 32'h2002, 32'h0, 5'd8), 32'h0, 0);
        chk("lhu_addr",   o_addr,         32'h2000);
        chk("lhu_be",     {28'b0, o_be},  32'hC);
        chk("lhu_stalls", o_stall_cnt,    32'd2);
        chk("lhu_wbv",    {31'b0, o_wbv}, 32'h1);
        chk("lhu_wbd",    o_wbd,          32'h0000_BEEF);

        // SB
        run_mem(mk(3'b000, 1'b0, 1'b1, 32'h3001, 32'h0, 5'd9), 32'hAABB_CCDD, 1);
        chk("sb_we",    {31'b0, o_we},  32'h1);
        chk("sb_addr",  o_addr,         32'h3000);
        chk("sb_be",    {28'b0, o_be},  32'h2);
        chk("sb_wdata", o_wdata,        32'hDDDD_DDDD);
        chk("sb_no_wb", {31'b0, o_wbv}, 32'h0);

        // Back-to-back SW then LW, next instruction presented as soon as stall drops
        run_mem(mk(3'b010, 1'b0, 1'b1, 32'h4000, 32'h0, 5'd1), 32'hCAFE_F00D, 1);
        chk("sw_wdata",    o_wdata,               32'hCAFE_F00D);
        chk("sw_be",       {28'b0, o_be},         32'hF);
        chk("sw_no_wb",    {31'b0, o_wbv},        32'h0);
        chk("sw_post_st",  {31'b0, o_post_stall}, 32'h0);
        run_mem(mk(3'b010, 1'b1, 1'b0, 32'h4000, 32'h0, 5'd9), 32'h0, 1);
        chk("lw_req",  {31'b0, o_req},  32'h1);
        chk("lw_we",   {31'b0, o_we},   32'h0);
        chk("lw_wbv",  {31'b0, o_wbv},  32'h1);
        chk("lw_wbr",  {27'b0, o_wbr},  32'd9);
        chk("lw_wbd",  o_wbd,           32'hCAFE_F00D);
        run_mem(mk(3'b001, 1'b1, 1'b0, 32'h4000, 32'h0, 5'd10), 32'h0, 0);
        chk("lh_be",   {28'b0, o_be},   32'h3);
        chk("lh_wbd",  o_wbd,           32'hFFFF_F00D);

        // re and we both set behaves as a store
        run_mem(mk(3'b000, 1'b1, 1'b1, 32'h4002, 32'h0, 5'd3), 32'h0000_0011, 0);
        chk("rw_we",    {31'b0, o_we},  32'h1);
        chk("rw_be",    {28'b0, o_be},  32'h4);
        chk("rw_no_wb", {31'b0, o_wbv}, 32'h0);
        run_mem(mk(3'b100, 1'b1, 1'b0, 32'h4002, 32'h0, 5'd4), 32'h0, 0);
        chk("lbu_wbd",  o_wbd,          32'h0000_0011);

        // ack while idle is ignored
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("idle_ack_wbv", {31'b0, wb_valid}, 32'h0);
        chk("idle_ack_req", {31'b0, bus_req},  32'h0);

        // reset while a load is outstanding
        valid_in   = 1'b1;
        signals_in = mk(3'b010, 1'b1, 1'b0, 32'h6000, 32'h0, 5'd4);
        tick();
        valid_in   = 1'b0;
        signals_in = '0;
        chk("mid_req_up", {31'b0, bus_req}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_req_async", {31'b0, bus_req}, 32'h0);
        chk("mid_stall",     {31'b0, stall},   32'h0);
        tick();
        reset_n   = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'h1234_5678;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        chk("late_ack_wbv", {31'b0, wb_valid}, 32'h0);
        chk("late_ack_req", {31'b0, bus_req},  32'h0);
        tick();
        chk("late_ack_wbv2", {31'b0, wb_valid}, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        valid_in   = 1'b1;
        signals_in = mk(3'b010, 1'b1, 1'b0, 32'h5002, 32'h0, 5'd11);
        #1;
        chk("mis_stall", {31'b0, stall}, 32'h0);
        tick();
        valid_in   = 1'b0;
        signals_in = '0;
        chk("mis_pulse",  {31'b0, misalign}, 32'h1);
        chk("mis_no_req", {31'b0, bus_req},  32'h0);
        chk("mis_no_wb",  {31'b0, wb_valid}, 32'h0);
        tick();
        chk("mis_drop",   {31'b0, misalign}, 32'h0);
        chk("mis_no_req2", {31'b0, bus_req}, 32'h0);
`else
        run_mem(mk(3'b010, 1'b1, 1'b0, 32'h5002, 32'h0, 5'd11), 32'h0, 0);
        chk("mis_req",   {31'b0, o_req},     32'h1);
        chk("mis_addr",  o_addr,             32'h5000);
        chk("mis_be",    {28'b0, o_be},      32'hF);
        chk("mis_wbv",   {31'b0, o_wbv},     32'h1);
        chk("mis_tied",  {31'b0, misalign},  32'h0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Memory stage, directly downstream of the integer execute unit; consumes its memory_signals bundle plus the store operand.
- Performs loads and stores over a simple request/acknowledge data bus. Sign- or zero-extends load data and drives a registered writeback bundle to the register file.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- BE_W, XLEN/8, byte-enable width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- valid_in  in  1  signals_in/store_data hold a valid instruction
- signals_in  in  memory_signals  funct3, mm_re, mm_we, mm_addr, data, rd_addr from execute
- store_data  in  XLEN  rs2 value for stores
- stall  out  1  upstream must hold its outputs this cycle
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  XLEN  word-aligned address (addr[1:0] = 0)
- bus_wdata  out  XLEN  lane-shifted store data
- bus_be  out  BE_W  byte enables
- bus_ack  in  1  transaction complete; rdata valid when ack is high on a read
- bus_rdata  in  XLEN  read word
- wb_valid  out  1  writeback bundle valid
- wb_rd_addr  out  5  destination register
- wb_rd_data  out  XLEN  writeback value
- misalign  out  1  misaligned access pulse (feature only)

Behaviour:
- Reset (async, reset_n = 0): state IDLE. bus_req, bus_we, wb_valid, misalign = 0. bus_addr, bus_wdata, bus_be, wb_rd_addr, wb_rd_data = 0.
- States: IDLE, BUS.
- IDLE, valid_in = 1, mm_re = mm_we = 0 (ALU or jump op):
  - Next cycle: wb_valid = 1, wb_rd_addr = rd_addr, wb_rd_data = signals_in.data.
  - Latency 1; stall = 0.
- IDLE, valid_in = 1, mm_re or mm_we set:
  - Latch bus_addr = {mm_addr[31:2], 2'b00}, bus_we = mm_we, funct3, rd_addr, byte offset mm_addr[1:0].
  - Next cycle: bus_req = 1; go to BUS.
  - stall is asserted combinationally in the accept cycle and in every BUS cycle.
  - wb_valid = 0 the cycle after accept.
- mm_re and mm_we both set: treated as a store.
- Byte enables and write data by funct3[1:0] (0 byte, 1 half, 2 word), off = addr[1:0]:
  - Byte: be = 0001 << off; wdata = {4{sd[7:0]}}.
  - Half: be = 0011 << off; wdata = {2{sd[15:0]}}.
  - Word: be = 1111; wdata = sd.
  - Reads drive the same be pattern.
- BUS state:
  - bus_req and all bus outputs stay constant until a cycle with bus_ack = 1.
  - On ack: bus_req drops the next cycle; state returns to IDLE.
  - Load: the cycle after ack, wb_valid = 1 with the extracted value. Select the lane by off; funct3[2] = 0 sign-extends, funct3[2] = 1 zero-extends (LB/LH/LW/LBU/LHU).
  - Store: wb_valid = 0.
  - stall deasserts in the cycle after ack, so upstream may present the next instruction then.
  - Minimum load latency: accept cycle + 1 request cycle with ack + 1 writeback cycle.
- bus_ack in IDLE: ignored.
- valid_in = 0 in IDLE: wb_valid = 0 next cycle; no state change.
- wb_valid is a single-cycle pulse per instruction; there is no downstream backpressure.
- Reset mid-transaction: bus_req drops immediately (async); no writeback; a late ack after reset is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half access with off[0] = 1 or a word access with off ≠ 0 is detected at accept.
  - No bus request is issued and no writeback occurs.
  - misalign pulses 1 the following cycle; stall = 0.
- Not defined: misalign is tied to 0. Misaligned accesses proceed using the be/wdata rules above; bits shifted past lane 3 are dropped.

Test Plan:
- ALU passthrough: valid_in = 1, mm_re = mm_we = 0, data = 0x1234_5678, rd = 5 -> next cycle wb_valid = 1, rd 5 = 0x12345678, bus_req never high.
- LB sign-extend: addr 0x1003, funct3 = 000, ack after 3 wait cycles with rdata 0x80FF_FF00 -> bus_addr 0x1000, be = 1000, wb_rd_data 0xFFFFFF80; stall high for 5 cycles.
- LHU: addr 0x2002, funct3 = 101, immediate ack, rdata 0xBEEF_0000 -> wb_rd_data 0x0000BEEF.
- SB: addr 0x3001, store_data 0xAABBCCDD -> be = 0010, wdata 0xDDDDDDDD, bus_we = 1, no wb_valid.
- Back-to-back: SW then LW to 0x4000, ack each after 1 cycle -> second request issued only after stall drops; load returns the stored word from the bus model.
- Reset during BUS: pull reset_n low with bus_req = 1 -> bus_req = 0 immediately; later ack produces no wb_valid. With LSU_MISALIGN_TRAP_EN, LW at 0x5002 -> misalign = 1 for one cycle, no bus_req.
